// File: rtl/add_accum.sv
// Handshaked accumulator: sums COUNT unsigned operands into an ACC_W-bit result.
// Define ADD_ACCUM_SAT_EN to clamp on overflow instead of wrapping.
module add_accum #(
    parameter int N     = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4,
    localparam int CW   = $clog2(COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic [N-1:0]     din_i,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic [ACC_W-1:0] dout_o,
    output logic             ovf_o,
    output logic [CW-1:0]    cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

    state_t             state_r;
    state_t             state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_s;
    logic [ACC_W-1:0]   acc_upd_s;
    logic [ACC_W:0]     sum_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic               ovf_r;
    logic               ovf_s;

    // Carry-preserving add of the zero-extended operand.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                               input logic [N-1:0]     b);
        return {1'b0, a} + (ACC_W + 1)'(b);
    endfunction

    // Sum and the value the accumulator takes on a transfer.
    always_comb begin
        sum_s = add_ext(acc_r, din_i);
`ifdef ADD_ACCUM_SAT_EN
        if (sum_s[ACC_W]) begin
            acc_upd_s = {ACC_W{1'b1}};
        end else begin
            acc_upd_s = sum_s[ACC_W-1:0];
        end
`else
        acc_upd_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state logic; clear_i overrides every handshake.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        if (clear_i) begin
            state_s = IDLE;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CW{1'b0}};
            ovf_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (din_valid_i) begin
                        acc_s = acc_upd_s;
                        cnt_s = cnt_r + CW'(1);
                        ovf_s = ovf_r | sum_s[ACC_W];
                        if (cnt_r == LAST_CNT) begin
                            state_s = DONE;
                        end else begin
                            state_s = ACCUM;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                DONE: begin
                    if (dout_ready_i) begin
                        state_s = IDLE;
                        acc_s   = {ACC_W{1'b0}};
                        cnt_s   = {CW{1'b0}};
                        ovf_s   = 1'b0;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    acc_s   = {ACC_W{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    ovf_s   = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
        end
    end

    assign din_ready_o  = (state_r != DONE);
    assign dout_valid_o = (state_r == DONE);
    assign dout_o       = acc_r;
    assign ovf_o        = ovf_r;
    assign cnt_o        = cnt_r;

endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: default build, ACC_W=5 overflow build and COUNT=1 build.
module tb_add_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] vld = 3'b000;
    logic [2:0] rdy = 3'b000;
    logic [2:0] clr = 3'b000;
    logic [3:0] din_a = 4'd0;
    logic [3:0] din_b = 4'd0;
    logic [3:0] din_c = 4'd0;

    logic       drdy_a, drdy_b, drdy_c;
    logic       dv_a, dv_b, dv_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic [7:0] dout_a;
    logic [4:0] dout_b;
    logic [7:0] dout_c;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic [0:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_accum #(.N(4), .ACC_W(8), .COUNT(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[0]),
        .din_valid_i(vld[0]), .din_ready_o(drdy_a), .din_i(din_a),
        .dout_valid_o(dv_a), .dout_ready_i(rdy[0]), .dout_o(dout_a),
        .ovf_o(ovf_a), .cnt_o(cnt_a)
    );

    add_accum #(.N(4), .ACC_W(5), .COUNT(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[1]),
        .din_valid_i(vld[1]), .din_ready_o(drdy_b), .din_i(din_b),
        .dout_valid_o(dv_b), .dout_ready_i(rdy[1]), .dout_o(dout_b),
        .ovf_o(ovf_b), .cnt_o(cnt_b)
    );

    add_accum #(.N(4), .ACC_W(8), .COUNT(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[2]),
        .din_valid_i(vld[2]), .din_ready_o(drdy_c), .din_i(din_c),
        .dout_valid_o(dv_c), .dout_ready_i(rdy[2]), .dout_o(dout_c),
        .ovf_o(ovf_c), .cnt_o(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on DUT k (others idle), then sample 1 time unit after the edge.
    task automatic step(input int k, input logic v, input logic [3:0] d,
                        input logic r, input logic c);
        vld = 3'b000;
        rdy = 3'b000;
        clr = 3'b000;
        vld[k] = v;
        rdy[k] = r;
        clr[k] = c;
        case (k)
            0:       din_a = d;
            1:       din_b = d;
            default: din_c = d;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input int k, input string tag, input logic ev, input int ed,
                           input int ec, input logic eo, input logic er);
        logic [31:0] ov, od, oc, oo, orr;
        case (k)
            0:       begin ov = 32'(dv_a); od = 32'(dout_a); oc = 32'(cnt_a); oo = 32'(ovf_a); orr = 32'(drdy_a); end
            1:       begin ov = 32'(dv_b); od = 32'(dout_b); oc = 32'(cnt_b); oo = 32'(ovf_b); orr = 32'(drdy_b); end
            default: begin ov = 32'(dv_c); od = 32'(dout_c); oc = 32'(cnt_c); oo = 32'(ovf_c); orr = 32'(drdy_c); end
        endcase
        chk({tag, ".dout_valid"}, ov, 32'(ev));
        chk({tag, ".dout"}, od, ed);
        chk({tag, ".cnt"}, oc, ec);
        chk({tag, ".ovf"}, oo, 32'(eo));
        chk({tag, ".din_ready"}, orr, 32'(er));
    endtask

    initial begin
        int gap;
        int exp_sum;

        // Reset all three instances.
        rst = 1'b1;
        step(0, 1'b1, 4'd7, 1'b1, 1'b1);
        rst = 1'b0;
        chk_out(0, "rst_a", 1'b0, 0, 0, 1'b0, 1'b1);
        chk_out(1, "rst_b", 1'b0, 0, 0, 1'b0, 1'b1);
        chk_out(2, "rst_c", 1'b0, 0, 0, 1'b0, 1'b1);

        // 1,2,3,4 back-to-back.
        step(0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk_out(0, "seq_1", 1'b0, 1, 1, 1'b0, 1'b1);
        step(0, 1'b1, 4'd2, 1'b0, 1'b0);
        step(0, 1'b1, 4'd3, 1'b0, 1'b0);
        chk_out(0, "seq_3", 1'b0, 6, 3, 1'b0, 1'b1);
        step(0, 1'b1, 4'd4, 1'b0, 1'b0);
        chk_out(0, "seq_done", 1'b1, 10, 4, 1'b0, 1'b0);

        // Stall in DONE with operands offered.
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1, 4'd15, 1'b0, 1'b0);
            chk_out(0, "stall", 1'b1, 10, 4, 1'b0, 1'b0);
        end
        step(0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk_out(0, "handshake", 1'b0, 0, 0, 1'b0, 1'b1);

        // Clear overrides a simultaneous transfer.
        step(0, 1'b1, 4'd5, 1'b0, 1'b0);
        step(0, 1'b1, 4'd6, 1'b0, 1'b0);
        chk_out(0, "pre_clear", 1'b0, 11, 2, 1'b0, 1'b1);
        step(0, 1'b1, 4'd7, 1'b0, 1'b1);
        chk_out(0, "clear", 1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk_out(0, "after_clear", 1'b1, 4, 4, 1'b0, 1'b0);

        // Clear while in DONE.
        step(0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_out(0, "clear_done", 1'b0, 0, 0, 1'b0, 1'b1);

        // Reset beats handshake and clear in DONE.
        step(0, 1'b1, 4'd1, 1'b0, 1'b0);
        step(0, 1'b1, 4'd2, 1'b0, 1'b0);
        step(0, 1'b1, 4'd3, 1'b0, 1'b0);
        step(0, 1'b1, 4'd4, 1'b0, 1'b0);
        chk_out(0, "pre_rst", 1'b1, 10, 4, 1'b0, 1'b0);
        rst = 1'b1;
        step(0, 1'b1, 4'd9, 1'b1, 1'b1);
        rst = 1'b0;
        chk_out(0, "rst_done", 1'b0, 0, 0, 1'b0, 1'b1);

        // Reset mid-accumulation with a transfer offered.
        step(0, 1'b1, 4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        step(0, 1'b1, 4'd3, 1'b0, 1'b0);
        rst = 1'b0;
        chk_out(0, "rst_mid", 1'b0, 0, 0, 1'b0, 1'b1);

        // 2,2,2,2 with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                step(0, 1'b0, 4'd15, 1'b0, 1'b0);
                chk(" gap.cnt", 32'(cnt_a), 32'(i));
            end
            step(0, 1'b1, 4'd2, 1'b0, 1'b0);
        end
        chk_out(0, "gaps", 1'b1, 8, 4, 1'b0, 1'b0);
        step(0, 1'b0, 4'd0, 1'b1, 1'b0);

        // ACC_W=5 overflow: 15 four times.
        step(1, 1'b1, 4'd15, 1'b0, 1'b0);
        step(1, 1'b1, 4'd15, 1'b0, 1'b0);
        chk_out(1, "ovf_2", 1'b0, 30, 2, 1'b0, 1'b1);
        step(1, 1'b1, 4'd15, 1'b0, 1'b0);
`ifdef ADD_ACCUM_SAT_EN
        chk_out(1, "ovf_3", 1'b0, 31, 3, 1'b1, 1'b1);
        step(1, 1'b1, 4'd15, 1'b0, 1'b0);
        chk_out(1, "ovf_4", 1'b1, 31, 4, 1'b1, 1'b0);
`else
        chk_out(1, "ovf_3", 1'b0, 13, 3, 1'b1, 1'b1);
        step(1, 1'b1, 4'd15, 1'b0, 1'b0);
        chk_out(1, "ovf_4", 1'b1, 28, 4, 1'b1, 1'b0);
`endif
        step(1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out(1, "ovf_clr", 1'b0, 0, 0, 1'b0, 1'b1);

        // COUNT=1: each operand returned individually.
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) step(2, 1'b0, 4'd0, 1'b0, 1'b0);
            exp_sum = 2 + i;
            step(2, 1'b1, 4'(exp_sum), 1'b0, 1'b0);
            chk_out(2, "single", 1'b1, exp_sum, 1, 1'b0, 1'b0);
            step(2, 1'b1, 4'd9, 1'b1, 1'b0);
            chk_out(2, "single_hs", 1'b0, 0, 0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
